// File: rtl/ads1293_pkg.sv
// Shared types and constants for the ADS1293 SPI register poller.
package ads1293_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_GAP      = 3'd4
  } state_e;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned BYTE_W  = 8;

  localparam logic              CMD_READ    = 1'b1;
  localparam logic              CMD_WRITE   = 1'b0;
  localparam logic [6:0]        CONFIG_ADDR = 7'h00;
  localparam logic [BYTE_W-1:0] CONFIG_VAL  = 8'h01;

  // Command byte followed by data byte, MSB first on the wire.
  function automatic logic [FRAME_W-1:0] spi_frame(input logic rw, input logic [6:0] addr,
                                                  input logic [BYTE_W-1:0] data);
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/ads1293_spi_core.sv
// SPI mode-0 shifter: sck generation, bit counter, tx/rx shift registers.
module ads1293_spi_core
  import ads1293_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] tx_word_i,
  input  logic               go_i,
  input  logic               miso_i,
  output logic               sck_o,
  output logic               mosi_o,
  output logic               last_c,
  output logic [BYTE_W-1:0]  rx_byte_o
);

  localparam int unsigned DIV_W = 8;

  logic [DIV_W-1:0]   div_q;
  logic [3:0]         bit_q;
  logic [FRAME_W-1:0] tx_q;
  logic [BYTE_W-1:0]  rx_q;
  logic               sck_q;
  logic               act_q;
  logic               tick_c;

  assign tick_c    = act_q && (div_q == DIV_W'(CLK_DIV - 1));
  assign last_c    = tick_c && sck_q && (bit_q == 4'd15);
  assign sck_o     = sck_q;
  assign mosi_o    = tx_q[FRAME_W-1];
  assign rx_byte_o = rx_q;

  // Half-period divider; mosi shifts on sck fall, miso captured on sck rise of bits 9-16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      bit_q <= '0;
      tx_q  <= '0;
      rx_q  <= '0;
      sck_q <= 1'b0;
      act_q <= 1'b0;
    end else if (load_i) begin
      div_q <= '0;
      bit_q <= '0;
      tx_q  <= tx_word_i;
      rx_q  <= '0;
      sck_q <= 1'b0;
      act_q <= 1'b0;
    end else if (go_i) begin
      // First rising edge: bit 1 is command, nothing to capture.
      div_q <= '0;
      sck_q <= 1'b1;
      act_q <= 1'b1;
    end else if (act_q) begin
      if (tick_c) begin
        div_q <= '0;
        sck_q <= ~sck_q;
        if (sck_q) begin
          tx_q  <= {tx_q[FRAME_W-2:0], 1'b0};
          bit_q <= bit_q + 4'd1;
          if (bit_q == 4'd15) act_q <= 1'b0;
        end else if (bit_q[3]) begin
          rx_q <= {rx_q[BYTE_W-2:0], miso_i};
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/ads1293.sv
// ADS1293 register poller: repeatedly reads REG_ADDR over SPI mode 0 while en is high.
// Build option: define ADS1293_INIT_EN to issue a CONFIG start-conversion write first after reset.
module ads1293
  import ads1293_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [6:0]  REG_ADDR = 7'h40,
  parameter int unsigned CS_GAP   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [BYTE_W-1:0] data_out,
  input  logic             miso,
  output logic             mosi,
  output logic             cs,
  output logic             sck,
  output logic             done
);

  localparam int unsigned CNT_W = 16;

`ifdef ADS1293_INIT_EN
  localparam logic INIT_EN = 1'b1;
`else
  localparam logic INIT_EN = 1'b0;
`endif

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               cs_q;
  logic               done_q;
  logic               rdy_q;
  logic               wr_q;
  logic               init_pend_q;
  logic [BYTE_W-1:0]  data_q;

  logic               load_c;
  logic               go_c;
  logic               last_c;
  logic [FRAME_W-1:0] frame_c;
  logic [BYTE_W-1:0]  rx_byte;

  assign load_c  = (state_q == ST_IDLE) && rdy_q && en;
  assign go_c    = (state_q == ST_CS_SETUP) && (cnt_q == CNT_W'(CLK_DIV - 1));
  assign frame_c = init_pend_q ? spi_frame(CMD_WRITE, CONFIG_ADDR, CONFIG_VAL)
                               : spi_frame(CMD_READ, REG_ADDR, '0);

  assign data_out = data_q;
  assign cs       = cs_q;
  assign done     = done_q;

  ads1293_spi_core #(.CLK_DIV(CLK_DIV)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load_c),
    .tx_word_i (frame_c),
    .go_i      (go_c),
    .miso_i    (miso),
    .sck_o     (sck),
    .mosi_o    (mosi),
    .last_c    (last_c),
    .rx_byte_o (rx_byte)
  );

  // Transaction sequencer: cs framing, setup/hold/gap timing, result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cs_q        <= 1'b1;
      done_q      <= 1'b0;
      rdy_q       <= 1'b0;
      wr_q        <= 1'b0;
      init_pend_q <= INIT_EN;
      data_q      <= '0;
    end else begin
      done_q <= 1'b0;
      // Holds off the first transaction until the second edge out of reset.
      rdy_q  <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (load_c) begin
            state_q     <= ST_CS_SETUP;
            cs_q        <= 1'b0;
            cnt_q       <= '0;
            wr_q        <= init_pend_q;
            init_pend_q <= 1'b0;
          end
        end
        ST_CS_SETUP: begin
          if (go_c) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_SHIFT: begin
          if (last_c) begin
            state_q <= ST_CS_HOLD;
            cnt_q   <= '0;
          end
        end
        ST_CS_HOLD: begin
          if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
            state_q <= ST_GAP;
            cs_q    <= 1'b1;
            cnt_q   <= '0;
            if (!wr_q) begin
              data_q <= rx_byte;
              done_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == CNT_W'(CS_GAP - 1)) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          cs_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ads1293.sv
// Self-checking bench for ads1293: SPI slave model, cycle-based bus monitor, directed steps.
module tb_ads1293;

  localparam int unsigned TB_DIV = 4;
  localparam int unsigned TB_GAP = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] data_out;
  logic       miso = 1'b0;
  logic       mosi;
  logic       cs;
  logic       sck;
  logic       done;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #10 clk = ~clk;

  ads1293 #(.CLK_DIV(TB_DIV), .REG_ADDR(7'h40), .CS_GAP(TB_GAP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .data_out (data_out),
    .miso     (miso),
    .mosi     (mosi),
    .cs       (cs),
    .sck      (sck),
    .done     (done)
  );

  // Slave model: new random response per cs-low window, shifted out MSB first on sck falling edges.
  bit          all_ones = 1'b0;
  bit          in_win   = 1'b0;
  logic [15:0] sl_sh    = '0;
  logic [7:0]  served   = '0;
  always @(cs or negedge sck) begin
    if (cs !== 1'b0) begin
      in_win = 1'b0;
    end else if (!in_win) begin
      in_win = 1'b1;
      served = all_ones ? 8'hFF : 8'($urandom);
      sl_sh  = {(all_ones ? 8'hFF : 8'($urandom)), served};
      miso   = sl_sh[15];
    end else begin
      sl_sh = {sl_sh[14:0], 1'b0};
      miso  = sl_sh[15];
    end
  end

  // Bus monitor, sampled mid-cycle; all times in clk cycles.
  bit          mon_clr = 1'b1;
  int          ncyc = 0, cs_falls = 0, wins = 0, done_cnt = 0, sck_edges = 0;
  int          win_rises = 0, last_rises = 0, setup_c = 0, hold_c = 0;
  int          hp_min = 1000, hp_max = 0, gap_min = 1000, dout_bad = 0;
  int          t_fall = 0, t_edge = 0, t_rise = 0;
  bit          edge_v = 1'b0, rise_v = 1'b0;
  logic [15:0] win_mosi = '0, last_mosi = '0;
  logic        cs_p = 1'b1, sck_p = 1'b0, rst_p = 1'b0;
  logic [7:0]  dout_p = '0;
  always @(negedge clk) begin
    ncyc++;
    if (mon_clr) begin
      cs_falls = 0; wins = 0; done_cnt = 0; sck_edges = 0; dout_bad = 0;
      hp_min = 1000; hp_max = 0; gap_min = 1000; edge_v = 1'b0; rise_v = 1'b0;
    end else begin
      if (done === 1'b1) done_cnt++;
      if (rst_n && rst_p && (data_out !== dout_p) && (done !== 1'b1)) dout_bad++;
      if (cs_p && !cs) begin
        cs_falls++; win_rises = 0; win_mosi = '0; t_fall = ncyc; edge_v = 1'b0;
        if (rise_v && (ncyc - t_rise) < gap_min) gap_min = ncyc - t_rise;
      end
      if (sck !== sck_p) begin
        sck_edges++;
        if (!cs) begin
          if (sck) begin
            win_rises++;
            win_mosi = {win_mosi[14:0], mosi};
          end
          if (edge_v) begin
            if ((ncyc - t_edge) < hp_min) hp_min = ncyc - t_edge;
            if ((ncyc - t_edge) > hp_max) hp_max = ncyc - t_edge;
          end else if (sck) begin
            setup_c = ncyc - t_fall;
          end
          t_edge = ncyc; edge_v = 1'b1;
        end
      end
      if (!cs_p && cs) begin
        wins++; last_rises = win_rises; last_mosi = win_mosi;
        if (edge_v) hold_c = ncyc - t_edge;
        t_rise = ncyc; rise_v = 1'b1; edge_v = 1'b0;
      end
    end
    cs_p = cs; sck_p = sck; rst_p = rst_n; dout_p = data_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_pulse();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic wait_rises(input int n, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      #1;
      if (cs === 1'b0 && win_rises >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // With the init option, the first window after reset must be the CONFIG write.
  task automatic skip_init();
`ifdef ADS1293_INIT_EN
    int         w0;
    int         d0;
    bit         seen;
    logic [7:0] dv;
    w0 = wins; d0 = done_cnt; dv = data_out; seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (wins != w0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("init_seen", 32'(seen), 32'd1);
    chk("init_mosi", 32'(last_mosi), 32'h0000_0001);
    chk("init_rises", 32'(last_rises), 32'd16);
    chk("init_no_done", 32'(done_cnt - d0), 32'd0);
    chk("init_dout", 32'(data_out), 32'(dv));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int lat;
    int c0;

    // Step 1: reset values.
    rst_n = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Step 2: en low after reset keeps the bus idle.
    rst_n = 1'b1;
    mon_pulse();
    repeat (1000) @(negedge clk);
    #1;
    chk("idle_cs_falls", 32'(cs_falls), 32'd0);
    chk("idle_sck_edges", 32'(sck_edges), 32'd0);
    chk("idle_done", 32'(done_cnt), 32'd0);
    chk("idle_cs", 32'(cs), 32'd1);

    // Step 3: start latency out of reset, then a read with miso held high.
    rst_n = 1'b0; en = 1'b1; all_ones = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (lat = 1; lat <= 20; lat++) begin
      @(posedge clk);
      #1;
      if (cs === 1'b0) break;
    end
    chk("start_latency_ok", 32'(lat >= 2 && lat <= 3), 32'd1);
    skip_init();
    wait_done(3000, ok);
    chk("ones_done_seen", 32'(ok), 32'd1);
    chk("ones_dout", 32'(data_out), 32'h0000_00FF);
    chk("ones_mosi", 32'(last_mosi), 32'h0000_C000);
    chk("ones_rises", 32'(last_rises), 32'd16);
    @(negedge clk);
    chk("done_width", 32'(done), 32'd0);

    // Step 4: back-to-back reads of random slave bytes.
    all_ones = 1'b0;
    mon_pulse();
    for (int k = 0; k < 6; k++) begin
      wait_done(3000, ok);
      chk("rd_done_seen", 32'(ok), 32'd1);
      chk("rd_dout", 32'(data_out), 32'(served));
      chk("rd_mosi", 32'(last_mosi), 32'h0000_C000);
      chk("rd_rises", 32'(last_rises), 32'd16);
    end
    chk("rd_windows", 32'(wins), 32'd6);
    chk("rd_done_count", 32'(done_cnt), 32'd6);
    chk("sck_half_min", 32'(hp_min), 32'(TB_DIV));
    chk("sck_half_max", 32'(hp_max), 32'(TB_DIV));
    chk("cs_setup", 32'(setup_c), 32'(TB_DIV));
    chk("cs_hold", 32'(hold_c), 32'(TB_DIV));
    chk("cs_gap_ok", 32'(gap_min >= int'(TB_GAP) && gap_min < 1000), 32'd1);
    chk("dout_stable", 32'(dout_bad), 32'd0);

    // Step 5: en dropped mid-transaction; the transaction still completes.
    wait_rises(5, 3000, ok);
    chk("enfall_reach", 32'(ok), 32'd1);
    en = 1'b0;
    wait_done(3000, ok);
    chk("enfall_done_seen", 32'(ok), 32'd1);
    chk("enfall_dout", 32'(data_out), 32'(served));
    chk("enfall_rises", 32'(last_rises), 32'd16);
    c0 = cs_falls;
    repeat (200) @(negedge clk);
    #1;
    chk("enfall_no_restart", 32'(cs_falls - c0), 32'd0);
    chk("enfall_cs_idle", 32'(cs), 32'd1);

    // Step 6: asynchronous reset during bit 10, then a clean transaction.
    en = 1'b1;
    wait_rises(10, 3000, ok);
    chk("abort_reach", 32'(ok), 32'd1);
    @(posedge clk);
    #3;
    chk("abort_pre_cs", 32'(cs), 32'd0);
    chk("abort_pre_sck", 32'(sck), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_cs", 32'(cs), 32'd1);
    chk("abort_sck", 32'(sck), 32'd0);
    chk("abort_dout", 32'(data_out), 32'd0);
    chk("abort_mosi", 32'(mosi), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_pulse();
    skip_init();
    wait_done(3000, ok);
    chk("post_done_seen", 32'(ok), 32'd1);
    chk("post_dout", 32'(data_out), 32'(served));
    chk("post_mosi", 32'(last_mosi), 32'h0000_C000);
    chk("post_rises", 32'(last_rises), 32'd16);
    chk("post_dout_stable", 32'(dout_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
